sram22_march_bist: RTL and testbench

//  Requester-side March C- BIST engine for a single-port SRAM22 macro (1-cycle read latency, registered dout).

---
 rtl/sram22_bist_pkg.sv | 49 ++++
 rtl/sram22_bist_addr_gen.sv | 49 ++++
 rtl/sram22_march_bist.sv | 273 +++++++++++++++++++++++++++
 tb/tb_sram22_march_bist.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram22_bist_pkg.sv
// rtl/sram22_bist_pkg.sv - March C- element and op definitions for the SRAM22 BIST engine
//
// Purpose: shared types and per-element constant tables for the March C- sequence.
// Tables are indexed by march element (bit n describes element Mn); bits 6..7 are unused.
// Ports: none (package).

package sram22_bist_pkg;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } march_elem_e;

  typedef enum logic {
    OP_R = 1'b0,
    OP_W = 1'b1
  } march_op_e;

  // Address direction: 1 = descending (RAM_DEPTH-1 .. 0)
  localparam logic [7:0] ELEM_DOWN   = 8'b0011_1000;
  // Element contains a read op / a write op
  localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;
  localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;
  // Data polarity of the read / write op: 1 = ~pattern
  localparam logic [7:0] ELEM_RD_INV = 8'b0001_0100;
  localparam logic [7:0] ELEM_WR_INV = 8'b0000_1010;

  // Read-then-write elements spend two cycles per address
  function automatic logic elem_two_phase(input march_elem_e e);
    return ELEM_HAS_RD[e] && ELEM_HAS_WR[e];
  endfunction

  // Op issued by element e; phase selects the write half of a two-phase element
  function automatic march_op_e elem_op(input march_elem_e e, input logic phase);
    if (elem_two_phase(e)) begin
      return phase ? OP_W : OP_R;
    end
    return ELEM_HAS_WR[e] ? OP_W : OP_R;
  endfunction

  function automatic logic elem_inv(input march_elem_e e, input march_op_e op);
    return (op == OP_W) ? ELEM_WR_INV[e] : ELEM_RD_INV[e];
  endfunction

endpackage

// File: rtl/sram22_bist_addr_gen.sv
// rtl/sram22_bist_addr_gen.sv - up/down address counter for the SRAM22 March BIST
//
// Purpose: holds the current march address. load_i presets it to 0 (up) or
// all-ones (down); step_i moves it one word in the direction given by down_i.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   load_i           preset the counter (has priority over step_i)
//   load_down_i      preset value select: 1 = RAM_DEPTH-1, 0 = 0
//   step_i           advance by one address
//   down_i           direction of step and of the end-address check
//   addr_o           current address
//   is_last_o        current address is the end address for direction down_i

module sram22_bist_addr_gen #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  load_down_i,
  input  logic                  step_i,
  input  logic                  down_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  is_last_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? '1 : '0;
    end else if (step_i) begin
      addr_d = down_i ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o    = addr_q;
  assign is_last_o = down_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/sram22_march_bist.sv
// rtl/sram22_march_bist.sv - March C- BIST engine driving one single-port SRAM22 macro
//
// Purpose: runs March C- (M0..M5) over the full SRAM, compares read data against
// the expected background and reports the first failure plus a saturating error count.
// Ports:
//   clk, rst                 clock (shared with the SRAM), async active-high reset
//   start, abort, pattern    control; pattern is the "0" background, latched on start
//   busy, done               status (busy in RUN/DRAIN, done level in DONE)
//   fail, fail_*             sticky first-miscompare record
//   err_count                saturating miscompare count
//   sram_we/wmask/addr/din   registered SRAM request
//   sram_dout                SRAM read data, valid the cycle after a read is presented

module sram22_march_bist
  import sram22_bist_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 10,
  parameter int WMASK_WIDTH  = 2,
  parameter int ERRCNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DATA_WIDTH-1:0]   pattern,
  output logic                    busy,
  output logic                    done,
  output logic                    fail,
  output logic [ADDR_WIDTH-1:0]   fail_addr,
  output logic [2:0]              fail_element,
  output logic [DATA_WIDTH-1:0]   fail_expected,
  output logic [DATA_WIDTH-1:0]   fail_data,
  output logic [ERRCNT_WIDTH-1:0] err_count,
  output logic                    sram_we,
  output logic [WMASK_WIDTH-1:0]  sram_wmask,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_din,
  input  logic [DATA_WIDTH-1:0]   sram_dout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [DATA_WIDTH-1:0]   pat_q, pat_d;
  march_elem_e             elem_q, elem_d;
  logic                    phase_q, phase_d;
  logic                    gen_done_q, gen_done_d;

  // Request stage: what the SRAM sees this cycle
  logic                    sram_we_q, sram_we_d;
  logic [WMASK_WIDTH-1:0]  sram_wmask_q, sram_wmask_d;
  logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0]   sram_din_q, sram_din_d;
  logic                    op_rd_q, op_rd_d;
  march_elem_e             op_elem_q, op_elem_d;
  logic [DATA_WIDTH-1:0]   op_exp_q, op_exp_d;

  // Compare stage: aligned with sram_dout
  logic                    cmp_valid_q, cmp_valid_d;
  logic [ADDR_WIDTH-1:0]   cmp_addr_q, cmp_addr_d;
  march_elem_e             cmp_elem_q, cmp_elem_d;
  logic [DATA_WIDTH-1:0]   cmp_exp_q, cmp_exp_d;

  logic                    done_q, done_d;
  logic                    fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]              fail_elem_q, fail_elem_d;
  logic [DATA_WIDTH-1:0]   fail_exp_q, fail_exp_d;
  logic [DATA_WIDTH-1:0]   fail_data_q, fail_data_d;
  logic [ERRCNT_WIDTH-1:0] err_q, err_d;

  logic                    running, start_ok, emit, addr_adv, miscmp;
  march_op_e               cur_op;
  logic [DATA_WIDTH-1:0]   cur_word;
  march_elem_e             next_elem;
  logic                    ag_load, ag_load_down, ag_step, ag_last;
  logic [ADDR_WIDTH-1:0]   ag_addr;

  assign running   = (state_q == S_RUN) || (state_q == S_DRAIN);
  // abort beats start, and start is ignored while busy
  assign start_ok  = start && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign emit      = (state_q == S_RUN) && !gen_done_q && !abort;
  assign cur_op    = elem_op(elem_q, phase_q);
  assign cur_word  = elem_inv(elem_q, cur_op) ? ~pat_q : pat_q;
  // Address moves after the last op at that address (write half of r,w elements)
  assign addr_adv  = emit && !(elem_two_phase(elem_q) && !phase_q);
  assign next_elem = (elem_q == M5) ? M5 : march_elem_e'(elem_q + 3'd1);

  assign ag_load      = start_ok || (addr_adv && ag_last && (elem_q != M5));
  assign ag_load_down = start_ok ? 1'b0 : ELEM_DOWN[next_elem];
  assign ag_step      = addr_adv && !ag_last;

  assign miscmp = cmp_valid_q && running && !abort && (sram_dout != cmp_exp_q);

  sram22_bist_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (ag_load),
    .load_down_i (ag_load_down),
    .step_i      (ag_step),
    .down_i      (ELEM_DOWN[elem_q]),
    .addr_o      (ag_addr),
    .is_last_o   (ag_last)
  );

  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    elem_d       = elem_q;
    phase_d      = phase_q;
    gen_done_d   = gen_done_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;
    fail_elem_d  = fail_elem_q;
    fail_exp_d   = fail_exp_q;
    fail_data_d  = fail_data_q;
    err_d        = err_q;
    // Request stage idles at all-zero between ops
    sram_we_d    = 1'b0;
    sram_wmask_d = '0;
    sram_addr_d  = '0;
    sram_din_d   = '0;
    op_rd_d      = 1'b0;
    op_elem_d    = M0;
    op_exp_d     = '0;
    cmp_valid_d  = op_rd_q && !abort;
    cmp_addr_d   = sram_addr_q;
    cmp_elem_d   = op_elem_q;
    cmp_exp_d    = op_exp_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d     = S_RUN;
          pat_d       = pattern;
          elem_d      = M0;
          phase_d     = 1'b0;
          gen_done_d  = 1'b0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
          fail_exp_d  = '0;
          fail_data_d = '0;
          err_d       = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gen_done_q) begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        // DRAIN: one cycle for the final M5 compare
        state_d = S_IDLE;
        if (!abort) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
    endcase

    if (emit) begin
      sram_we_d    = (cur_op == OP_W);
      sram_wmask_d = '1;
      sram_addr_d  = ag_addr;
      sram_din_d   = (cur_op == OP_W) ? cur_word : '0;
      op_rd_d      = (cur_op == OP_R);
      op_elem_d    = elem_q;
      op_exp_d     = cur_word;
      if (elem_two_phase(elem_q) && !phase_q) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (ag_last) begin
          if (elem_q == M5) begin
            gen_done_d = 1'b1;
          end else begin
            elem_d = next_elem;
          end
        end
      end
    end

    if (miscmp) begin
      if (err_q != '1) begin
        err_d = err_q + ERRCNT_WIDTH'(1);
      end
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
        fail_exp_d  = cmp_exp_q;
        fail_data_d = sram_dout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pat_q        <= '0;
      elem_q       <= M0;
      phase_q      <= 1'b0;
      gen_done_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_wmask_q <= '0;
      sram_addr_q  <= '0;
      sram_din_q   <= '0;
      op_rd_q      <= 1'b0;
      op_elem_q    <= M0;
      op_exp_q     <= '0;
      cmp_valid_q  <= 1'b0;
      cmp_addr_q   <= '0;
      cmp_elem_q   <= M0;
      cmp_exp_q    <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_elem_q  <= '0;
      fail_exp_q   <= '0;
      fail_data_q  <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      elem_q       <= elem_d;
      phase_q      <= phase_d;
      gen_done_q   <= gen_done_d;
      sram_we_q    <= sram_we_d;
      sram_wmask_q <= sram_wmask_d;
      sram_addr_q  <= sram_addr_d;
      sram_din_q   <= sram_din_d;
      op_rd_q      <= op_rd_d;
      op_elem_q    <= op_elem_d;
      op_exp_q     <= op_exp_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_addr_q   <= cmp_addr_d;
      cmp_elem_q   <= cmp_elem_d;
      cmp_exp_q    <= cmp_exp_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
      fail_elem_q  <= fail_elem_d;
      fail_exp_q   <= fail_exp_d;
      fail_data_q  <= fail_data_d;
      err_q        <= err_d;
    end
  end

  assign busy          = running;
  assign done          = done_q;
  assign fail          = fail_q;
  assign fail_addr     = fail_addr_q;
  assign fail_element  = fail_elem_q;
  assign fail_expected = fail_exp_q;
  assign fail_data     = fail_data_q;
  assign err_count     = err_q;
  assign sram_we       = sram_we_q;
  assign sram_wmask    = sram_wmask_q;
  assign sram_addr     = sram_addr_q;
  assign sram_din      = sram_din_q;

endmodule

// File: tb/tb_sram22_march_bist.sv
// tb/tb_sram22_march_bist.sv - scoreboard bench for sram22_march_bist with an SRAM22 1024x64 model

module tb_sram22_march_bist;

  localparam int DW        = 64;
  localparam int AW        = 10;
  localparam int MW        = 2;
  localparam int EW        = 16;
  localparam int DEPTH     = 1024;
  localparam int RUN_EDGES = 10 * DEPTH + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] pattern = '0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_element;
  logic [DW-1:0] fail_expected, fail_data;
  logic [EW-1:0] err_count;
  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;

  always #5 clk = ~clk;

  sram22_march_bist #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .ERRCNT_WIDTH(EW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_element(fail_element), .fail_expected(fail_expected), .fail_data(fail_data),
    .err_count(err_count), .sram_we(sram_we), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // SRAM22 behavioural model: 1-cycle registered read, per-lane write mask,
  // optional stuck-at-1 on bit 3 of word 5 (read path only)
  logic [DW-1:0] mem [DEPTH];
  logic          fault_en = 1'b0;

  always @(posedge clk) begin
    if (sram_we) begin
      for (int l = 0; l < MW; l++) begin
        if (sram_wmask[l]) mem[sram_addr][l*32 +: 32] <= sram_din[l*32 +: 32];
      end
    end else begin
      sram_dout <= mem[sram_addr] | ((fault_en && sram_addr == AW'(5)) ? 64'h8 : 64'h0);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            done_cyc;
    logic          f;
    logic [EW-1:0] err;
    logic [AW-1:0] a;
    logic [2:0]    el;
    logic [DW-1:0] ex;
    logic [DW-1:0] da;
  } exp_t;

  exp_t sb_q[$];

  task automatic push_exp(input int dc, input logic f, input logic [EW-1:0] err,
                          input logic [AW-1:0] a, input logic [2:0] el,
                          input logic [DW-1:0] ex, input logic [DW-1:0] da);
    exp_t e;
    e.done_cyc = dc; e.f = f; e.err = err; e.a = a; e.el = el; e.ex = ex; e.da = da;
    sb_q.push_back(e);
  endtask

  // Monitor: every rising edge of done retires one expected run result
  logic done_prev = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done && !done_prev) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check("done_latency", 64'(cyc), 64'(e.done_cyc));
        check("done_busy", 64'(busy), 64'(0));
        check("run_fail", 64'(fail), 64'(e.f));
        check("run_err_count", 64'(err_count), 64'(e.err));
        check("run_fail_addr", 64'(fail_addr), 64'(e.a));
        check("run_fail_element", 64'(fail_element), 64'(e.el));
        check("run_fail_expected", fail_expected, e.ex);
        check("run_fail_data", fail_data, e.da);
      end
    end
    done_prev <= done;
  end

  task automatic pulse_start(input logic [DW-1:0] p, output int s);
    @(negedge clk);
    pattern = p;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    s       = cyc;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_done(input int s);
    while (!done && cyc < s + RUN_EDGES + 20) @(negedge clk);
    check("done_seen", 64'(done), 64'(1));
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 64'({busy, done, fail, fail_addr, fail_element, err_count,
                               sram_we, sram_wmask, sram_addr}), 64'(0));
    check({tag, "_fail_expected"}, fail_expected, 64'(0));
    check({tag, "_fail_data"}, fail_data, 64'(0));
    check({tag, "_sram_din"}, sram_din, 64'(0));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s;
    // Reset state
    #2 rst = 1'b1;
    #2 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // start + abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", 64'(busy), 64'(0));

    // 1: clean run, pattern 0
    pulse_start(64'h0, s);
    check("t1_busy", 64'(busy), 64'(1));
    push_exp(s + RUN_EDGES, 1'b0, '0, '0, '0, '0, '0);
    wait_until(s + RUN_EDGES - 1);
    check("t1_drain_busy", 64'(busy), 64'(1));
    check("t1_drain_done", 64'(done), 64'(0));
    wait_done(s);

    // 2: stuck-at-1 on bit 3 of word 5
    fault_en = 1'b1;
    pulse_start(64'h0, s);
    push_exp(s + RUN_EDGES, 1'b1, 16'd3, 10'd5, 3'd1, 64'h0, 64'h8);
    wait_done(s);

    // 6: start from DONE restarts; a start while busy is ignored
    fault_en = 1'b0;
    pulse_start(64'h0, s);
    check("t6_done_drops", 64'(done), 64'(0));
    check("t6_err_cleared", 64'(err_count), 64'(0));
    check("t6_fail_cleared", 64'(fail), 64'(0));
    push_exp(s + RUN_EDGES, 1'b0, '0, '0, '0, '0, '0);
    wait_until(s + 500);
    pattern = 64'hFFFF_0000_FFFF_0000;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_done(s);

    // 3: inverted-background op checks, then 5: async reset mid-M4
    pulse_start(64'hA5A5_A5A5_A5A5_A5A5, s);
    check("t3_cycle0_we", 64'(sram_we), 64'(0));
    wait_until(s + 1);
    check("t3_m0_we", 64'(sram_we), 64'(1));
    check("t3_m0_addr", 64'(sram_addr), 64'(0));
    check("t3_m0_din", sram_din, 64'hA5A5_A5A5_A5A5_A5A5);
    check("t3_m0_wmask", 64'(sram_wmask), 64'(3));
    wait_until(s + 1025);
    check("t3_m1_rd_we", 64'(sram_we), 64'(0));
    check("t3_m1_rd_din", sram_din, 64'(0));
    wait_until(s + 1026);
    check("t3_m1_wr_we", 64'(sram_we), 64'(1));
    check("t3_m1_wr_addr", 64'(sram_addr), 64'(0));
    check("t3_m1_wr_din", sram_din, 64'h5A5A_5A5A_5A5A_5A5A);
    wait_until(s + 5121);
    check("t3_m3_first_we", 64'(sram_we), 64'(0));
    check("t3_m3_first_addr", 64'(sram_addr), 64'(1023));
    wait_until(s + 8000);
    #2 rst = 1'b1;
    #1 check_all_zero("t5_async_rst");
    #1 rst = 1'b0;
    pulse_start(64'h0, s);
    push_exp(s + RUN_EDGES, 1'b0, '0, '0, '0, '0, '0);
    wait_done(s);

    // 4: abort mid-M2 with an earlier miscompare, then a clean restart
    fault_en = 1'b1;
    pulse_start(64'h0, s);
    wait_until(s + 4000);
    check("t4_pre_abort_err", 64'(err_count), 64'(1));
    check("t4_pre_abort_addr", 64'(fail_addr), 64'(5));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_abort_busy", 64'(busy), 64'(0));
    check("t4_abort_done", 64'(done), 64'(0));
    check("t4_abort_we", 64'(sram_we), 64'(0));
    check("t4_abort_err_kept", 64'(err_count), 64'(1));
    fault_en = 1'b0;
    pulse_start(64'h0, s);
    check("t4_restart_err_cleared", 64'(err_count), 64'(0));
    push_exp(s + RUN_EDGES, 1'b0, '0, '0, '0, '0, '0);
    wait_done(s);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
